// File: rtl/systolic_feeder.sv
// Operand buffer and diagonal-skew feeder for a SIZE x SIZE systolic PE array.
// Sequences accumulator clear, skewed feed and drain, then pulses done.

module systolic_feeder_lane #(
    parameter int N    = 8,
    parameter int SIZE = 4,
    parameter int LANE = 0,
    parameter int CW   = 4
) (
    input  logic [SIZE-1:0][N-1:0] vec,
    input  logic [CW-1:0]          step,
    output logic [N-1:0]           q
);
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [CW:0] k;

    // Lane LANE lags the feed step by LANE cycles; outside the window it pads zero.
    always_comb begin
        k = {1'b0, step} - (CW+1)'(LANE);
        q = '0;
        if (({1'b0, step} >= (CW+1)'(LANE)) && (k < (CW+1)'(SIZE)))
            q = vec[k[IW-1:0]];
    end
endmodule

module systolic_feeder #(
    parameter int N    = 8,
    parameter int SIZE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_mat,
    input  logic [$clog2(SIZE)-1:0] wr_row,
    input  logic [$clog2(SIZE)-1:0] wr_col,
    input  logic [N-1:0]            wr_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    acc_clr,
    output logic                    feed_valid,
    output logic [SIZE*N-1:0]       a_out,
    output logic [SIZE*N-1:0]       b_out
);
    localparam int CW = $clog2(3*SIZE);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t  state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] step_nxt;

    // a_buf[row][col]; B is held column-major so each north lane sees one column.
    logic [SIZE-1:0][SIZE-1:0][N-1:0] a_buf;
    logic [SIZE-1:0][SIZE-1:0][N-1:0] b_col;
    logic [SIZE-1:0][N-1:0]           a_nxt;
    logic [SIZE-1:0][N-1:0]           b_nxt;

    assign step_nxt = (state == FEED) ? cnt + CW'(1) : '0;

    for (genvar l = 0; l < SIZE; l++) begin : g_lane
        systolic_feeder_lane #(.N(N), .SIZE(SIZE), .LANE(l), .CW(CW)) u_a (
            .vec(a_buf[l]), .step(step_nxt), .q(a_nxt[l]));
        systolic_feeder_lane #(.N(N), .SIZE(SIZE), .LANE(l), .CW(CW)) u_b (
            .vec(b_col[l]), .step(step_nxt), .q(b_nxt[l]));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            a_buf      <= '0;
            b_col      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            acc_clr    <= 1'b0;
            feed_valid <= 1'b0;
            a_out      <= '0;
            b_out      <= '0;
        end else begin
            done       <= 1'b0;
            acc_clr    <= 1'b0;
            feed_valid <= 1'b0;
            a_out      <= '0;
            b_out      <= '0;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        if (wr_mat) b_col[wr_col][wr_row] <= wr_data;
                        else        a_buf[wr_row][wr_col] <= wr_data;
                    end
                    if (start) begin
                        state   <= CLEAR;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        acc_clr <= 1'b1;
                    end
                end
                CLEAR: begin
                    state      <= FEED;
                    cnt        <= '0;
                    feed_valid <= 1'b1;
                    a_out      <= a_nxt;
                    b_out      <= b_nxt;
                end
                FEED: begin
                    if (cnt == CW'(2*SIZE-2)) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt        <= cnt + CW'(1);
                        feed_valid <= 1'b1;
                        a_out      <= a_nxt;
                        b_out      <= b_nxt;
                    end
                end
                DRAIN: begin
                    if (cnt == CW'(SIZE-2)) begin
                        state <= DONE;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
